// File: rtl/loop_flow_ctrl_sel_mux_if.sv
// Handshake and mux-data bundle between a parent/loop body and loop_flow_ctrl_sel_mux.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface loop_flow_ctrl_sel_mux_if #(
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 21,
    parameter int din2_WIDTH = 21,
    parameter int din3_WIDTH = 2,
    parameter int dout_WIDTH = 21
);
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_done;
    logic                  ap_start_int;
    logic                  ap_loop_init;
    logic                  ap_ready_int;
    logic                  ap_loop_exit_ready;
    logic                  ap_loop_exit_done;
    logic                  ap_continue_int;
    logic                  ap_done_int;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic [din2_WIDTH-1:0] din2;
    logic [din3_WIDTH-1:0] din3;
    logic [dout_WIDTH-1:0] dout;

    modport slave (
        input  ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int,
        input  din0, din1, din2, din3,
        output ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int, dout
    );

    modport master (
        output ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int,
        output din0, din1, din2, din3,
        input  ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int, dout
    );
endinterface

// File: rtl/loop_flow_ctrl_sel_mux.sv
// Loop start/exit handshake controller with a first-iteration flag, plus a
// zero-latency 3:1 data-select mux indexed by a 2-bit loop index.
module loop_flow_ctrl_sel_mux #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 1,
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 21,
    parameter int din2_WIDTH = 21,
    parameter int din3_WIDTH = 2,
    parameter int dout_WIDTH = 21
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    loop_flow_ctrl_sel_mux_if.slave bus
);

    // Armed flag: set on reset and on every loop exit, cleared once an iteration is consumed.
    logic loop_init_r;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            loop_init_r <= 1'b1;
        end else if (bus.ap_loop_exit_ready) begin
            loop_init_r <= 1'b1;
        end else if (bus.ap_ready_int) begin
            loop_init_r <= 1'b0;
        end
    end

    assign bus.ap_start_int    = bus.ap_start;
    assign bus.ap_ready        = bus.ap_loop_exit_ready;
    assign bus.ap_done         = bus.ap_loop_exit_done;
    assign bus.ap_continue_int = 1'b1;
    assign bus.ap_loop_init    = loop_init_r & bus.ap_start;

    // Each data input is resized to the output width: zero-extend if narrower, keep LSBs if wider.
    logic [dout_WIDTH-1:0] d0_ext;
    logic [dout_WIDTH-1:0] d1_ext;
    logic [dout_WIDTH-1:0] d2_ext;

    generate
        if (din0_WIDTH >= dout_WIDTH) begin : g_d0_trunc
            assign d0_ext = bus.din0[dout_WIDTH-1:0];
        end else begin : g_d0_zext
            assign d0_ext = {{(dout_WIDTH - din0_WIDTH){1'b0}}, bus.din0};
        end

        if (din1_WIDTH >= dout_WIDTH) begin : g_d1_trunc
            assign d1_ext = bus.din1[dout_WIDTH-1:0];
        end else begin : g_d1_zext
            assign d1_ext = {{(dout_WIDTH - din1_WIDTH){1'b0}}, bus.din1};
        end

        if (din2_WIDTH >= dout_WIDTH) begin : g_d2_trunc
            assign d2_ext = bus.din2[dout_WIDTH-1:0];
        end else begin : g_d2_zext
            assign d2_ext = {{(dout_WIDTH - din2_WIDTH){1'b0}}, bus.din2};
        end
    endgenerate

    // Two-level tree: sel[0] picks within each pair, sel[1] picks the pair; upper pair is din2 twice.
    logic [dout_WIDTH-1:0] mux_lo;
    logic [dout_WIDTH-1:0] mux_hi;

    assign mux_lo   = bus.din3[0] ? d1_ext : d0_ext;
    assign mux_hi   = d2_ext;
    assign bus.dout = bus.din3[1] ? mux_hi : mux_lo;

    // ap_done_int is monitor-only and the instance parameters carry no function.
    logic unused_ok;
    assign unused_ok = ^{bus.ap_done_int, ID[0], NUM_STAGE[0]};

endmodule

// File: tb/tb_loop_flow_ctrl_sel_mux.sv
// Bench for loop_flow_ctrl_sel_mux: directed handshake sequences, a mux vector table,
// and randomized traffic compared with an iteration-count reference model.
module tb_loop_flow_ctrl_sel_mux;

    localparam int W = 21;

    logic ap_clk = 1'b0;
    logic ap_rst;

    always #5 ap_clk = ~ap_clk;

    loop_flow_ctrl_sel_mux_if bus ();

    loop_flow_ctrl_sel_mux dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_ctrl(input logic start, input logic rdy, input logic ex_rdy, input logic ex_done);
        bus.ap_start           = start;
        bus.ap_ready_int       = rdy;
        bus.ap_loop_exit_ready = ex_rdy;
        bus.ap_loop_exit_done  = ex_done;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] exp;
    } mux_vec_t;

    mux_vec_t vecs[10];

    // Reference model state: iterations consumed since the last reset or exit.
    int iter_cnt;

    initial begin
        vecs[0] = '{2'd0, 21'd163840, 21'd5, 21'd7, 21'd163840};
        vecs[1] = '{2'd1, 21'd163840, 21'd5, 21'd7, 21'd5};
        vecs[2] = '{2'd2, 21'd163840, 21'd5, 21'd7, 21'd7};
        vecs[3] = '{2'd3, 21'd163840, 21'd5, 21'd7, 21'd7};
        vecs[4] = '{2'd0, 21'd163840, 21'd163840, 21'd163840, 21'd163840};
        vecs[5] = '{2'd1, 21'd163840, 21'd163840, 21'd163840, 21'd163840};
        vecs[6] = '{2'd2, 21'd163840, 21'd163840, 21'd163840, 21'd163840};
        vecs[7] = '{2'd3, 21'd163840, 21'd163840, 21'd163840, 21'd163840};
        vecs[8] = '{2'd1, 21'h1FFFFF, 21'h000000, 21'h155555, 21'h000000};
        vecs[9] = '{2'd3, 21'h1FFFFF, 21'h0AAAAA, 21'h100001, 21'h100001};

        ap_rst = 1'b1;
        set_ctrl(0, 0, 0, 0);
        bus.ap_done_int = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        bus.din2 = '0;
        bus.din3 = '0;

        // Reset state with inputs low
        tick();
        tick();
        check("rst_ap_ready", bus.ap_ready, 0);
        check("rst_ap_done", bus.ap_done, 0);
        check("rst_start_int", bus.ap_start_int, 0);
        check("rst_loop_init", bus.ap_loop_init, 0);
        check("rst_continue", bus.ap_continue_int, 1);
        ap_rst = 1'b0;
        tick();
        check("armed_no_start", bus.ap_loop_init, 0);
        bus.ap_start = 1'b1;
        #1;
        check("start_init_comb", bus.ap_loop_init, 1);
        check("start_int_comb", bus.ap_start_int, 1);

        // Three iterations, exit on the fourth, re-armed on the fifth
        set_ctrl(1, 1, 0, 0); #1;
        check("run_c1_init", bus.ap_loop_init, 1);
        tick();
        check("run_c2_init", bus.ap_loop_init, 0);
        tick();
        check("run_c3_init", bus.ap_loop_init, 0);
        tick();
        set_ctrl(1, 1, 1, 0); #1;
        check("run_c4_init", bus.ap_loop_init, 0);
        check("run_c4_ready", bus.ap_ready, 1);
        tick();
        set_ctrl(1, 0, 0, 0); #1;
        check("run_c5_init", bus.ap_loop_init, 1);
        check("run_c5_ready", bus.ap_ready, 0);

        // Single-iteration run: ready_int and exit together keep the flag armed
        set_ctrl(1, 1, 1, 0); #1;
        check("single_init", bus.ap_loop_init, 1);
        tick();
        set_ctrl(1, 0, 0, 0); #1;
        check("single_next_init", bus.ap_loop_init, 1);

        // Reset mid-run re-arms
        set_ctrl(1, 1, 0, 0);
        tick();
        tick();
        set_ctrl(1, 0, 0, 0); #1;
        check("mid_run_disarmed", bus.ap_loop_init, 0);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        #1;
        check("post_rst_init", bus.ap_loop_init, 1);

        // Done/ready pass-throughs
        set_ctrl(0, 0, 0, 1); #1;
        check("done_pass_hi", bus.ap_done, 1);
        set_ctrl(0, 0, 1, 0); #1;
        check("ready_pass_hi", bus.ap_ready, 1);
        check("done_pass_lo", bus.ap_done, 0);
        set_ctrl(0, 0, 0, 0); #1;
        check("ready_pass_lo", bus.ap_ready, 0);

        // Mux vector table
        for (int i = 0; i < 10; i++) begin
            bus.din0 = vecs[i].d0;
            bus.din1 = vecs[i].d1;
            bus.din2 = vecs[i].d2;
            bus.din3 = vecs[i].sel;
            #1;
            check($sformatf("mux_vec%0d", i), 32'(bus.dout), 32'(vecs[i].exp));
        end

        // Randomized traffic against the reference model
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        iter_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            logic [W-1:0] words[3];
            logic [1:0]   sel;
            logic         r_start, r_rdy, r_exit, r_done, r_rst;
            r_start = 1'($urandom_range(0, 3) != 0);
            r_rdy   = 1'($urandom_range(0, 1));
            r_exit  = 1'($urandom_range(0, 5) == 0);
            r_done  = 1'($urandom_range(0, 3) == 0);
            r_rst   = 1'($urandom_range(0, 39) == 0);
            sel     = 2'($urandom_range(0, 3));
            words[0] = W'($urandom);
            words[1] = W'($urandom);
            words[2] = W'($urandom);
            set_ctrl(r_start, r_rdy, r_exit, r_done);
            bus.din0 = words[0];
            bus.din1 = words[1];
            bus.din2 = words[2];
            bus.din3 = sel;
            ap_rst   = r_rst;
            #1;
            check("rnd_loop_init", bus.ap_loop_init, (r_start && iter_cnt == 0) ? 1 : 0);
            check("rnd_ready", bus.ap_ready, r_exit);
            check("rnd_done", bus.ap_done, r_done);
            check("rnd_start_int", bus.ap_start_int, r_start);
            check("rnd_mux", 32'(bus.dout), 32'(words[(sel > 2'd2) ? 2 : sel]));
            tick();
            if (r_rst || r_exit) iter_cnt = 0;
            else if (r_rdy) iter_cnt++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
